// File: rtl/rggen_register_access_initiator_pkg.sv
// Shared FSM encodings and elaboration-time helpers for the register access initiator.
package rggen_register_access_initiator_pkg;

   localparam logic [1:0] StIdle     = 2'b00;
   localparam logic [1:0] StAccess   = 2'b01;
   localparam logic [1:0] StResponse = 2'b10;

   // Ceiling log2; clog2(1) == 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Keeps derived vector widths legal when a count collapses to zero.
   function automatic int unsigned at_least_one(input int unsigned value);
      return (value == 0) ? 1 : value;
   endfunction

endpackage

// File: rtl/rggen_register_address_decoder.sv
// Per-slot word-address compare with lowest-index priority; purely combinational.
module rggen_register_address_decoder
   import rggen_register_access_initiator_pkg::*;
#(
   parameter int unsigned                               ADDRESS_WIDTH    = 8,
   parameter int unsigned                               DATA_WIDTH       = 32,
   parameter int unsigned                               REGISTERS        = 4,
   parameter logic [REGISTERS*ADDRESS_WIDTH-1:0]        REGISTER_ADDRESS = '0
) (
   input  logic [ADDRESS_WIDTH-1:0] address_i,
   output logic [REGISTERS-1:0]     hit_vector_o,
   output logic                     hit_o
);

   // Byte-offset bits inside one data word never take part in the match.
   localparam int unsigned Lsb = clog2(DATA_WIDTH / 8);

   logic found;

   // First matching slot claims the access so the select stays one-hot.
   always_comb begin
      hit_vector_o = '0;
      found        = 1'b0;
      for (int i = 0; i < REGISTERS; i++) begin
         if (!found &&
             ((address_i >> Lsb) == (REGISTER_ADDRESS[i*ADDRESS_WIDTH+:ADDRESS_WIDTH] >> Lsb))) begin
            hit_vector_o[i] = 1'b1;
            found           = 1'b1;
         end
      end
      hit_o = found;
   end

endmodule

// File: rtl/rggen_register_access_initiator.sv
// Bus-side master of the bit-field interface: one host request in flight, decoded to a register,
// driven onto that register's bit-field port, answered with a single held response.
module rggen_register_access_initiator
   import rggen_register_access_initiator_pkg::*;
#(
   parameter int unsigned                        ADDRESS_WIDTH    = 8,
   parameter int unsigned                        DATA_WIDTH       = 32,
   parameter int unsigned                        REGISTERS        = 4,
   parameter logic [REGISTERS*ADDRESS_WIDTH-1:0] REGISTER_ADDRESS = '0,
   parameter int unsigned                        TIMEOUT_CYCLES   = 15,
   parameter bit                                 ERROR_STATUS     = 1'b1
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_request_valid,
   output logic                            o_request_ready,
   input  logic                            i_request_write,
   input  logic [ADDRESS_WIDTH-1:0]        i_request_address,
   input  logic [DATA_WIDTH-1:0]           i_request_write_data,
   input  logic [DATA_WIDTH/8-1:0]         i_request_strobe,
   output logic                            o_response_valid,
   input  logic                            i_response_ready,
   output logic                            o_response_error,
   output logic [DATA_WIDTH-1:0]           o_response_read_data,
   output logic [REGISTERS-1:0]            o_bit_field_valid,
   output logic [DATA_WIDTH-1:0]           o_bit_field_read_mask,
   output logic [DATA_WIDTH-1:0]           o_bit_field_write_mask,
   output logic [DATA_WIDTH-1:0]           o_bit_field_write_data,
   input  logic [REGISTERS-1:0]            i_bit_field_ready,
   input  logic [REGISTERS*DATA_WIDTH-1:0] i_bit_field_read_data
);

   localparam int unsigned CountWidth = at_least_one(clog2(TIMEOUT_CYCLES + 1));

   logic [1:0]            state_q, state_d;
   logic                  write_q, write_d;
   logic [REGISTERS-1:0]  bf_valid_q, bf_valid_d;
   logic [DATA_WIDTH-1:0] read_mask_q, read_mask_d;
   logic [DATA_WIDTH-1:0] write_mask_q, write_mask_d;
   logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
   logic [CountWidth-1:0] count_q, count_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_error_q, resp_error_d;
   logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

   logic [REGISTERS-1:0]  hit_vector;
   logic                  hit;
   logic [DATA_WIDTH-1:0] strobe_mask;
   logic [DATA_WIDTH-1:0] selected_data;
   logic                  access_done;
   logic                  timed_out;

   rggen_register_address_decoder #(
      .ADDRESS_WIDTH    (ADDRESS_WIDTH),
      .DATA_WIDTH       (DATA_WIDTH),
      .REGISTERS        (REGISTERS),
      .REGISTER_ADDRESS (REGISTER_ADDRESS)
   ) u_decoder (
      .address_i    (i_request_address),
      .hit_vector_o (hit_vector),
      .hit_o        (hit)
   );

   // Byte strobes widened to bits, plus the read data and ready of the selected slot only.
   always_comb begin
      strobe_mask   = '0;
      selected_data = '0;
      for (int j = 0; j < DATA_WIDTH; j++) begin
         strobe_mask[j] = i_request_strobe[j/8];
      end
      for (int i = 0; i < REGISTERS; i++) begin
         if (bf_valid_q[i]) begin
            selected_data = selected_data | i_bit_field_read_data[i*DATA_WIDTH+:DATA_WIDTH];
         end
      end
      access_done = |(i_bit_field_ready & bf_valid_q);
      // Expiry is the cycle the counter would reach TIMEOUT_CYCLES; a same-cycle ready wins.
      timed_out   = (TIMEOUT_CYCLES != 0) &&
                    (({1'b0, count_q} + (CountWidth+1)'(1)) == (CountWidth+1)'(TIMEOUT_CYCLES));
   end

   // Next-state for the IDLE -> ACCESS -> RESPONSE handshake and all registered outputs.
   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      bf_valid_d   = bf_valid_q;
      read_mask_d  = read_mask_q;
      write_mask_d = write_mask_q;
      write_data_d = write_data_q;
      count_d      = count_q;
      resp_valid_d = resp_valid_q;
      resp_error_d = resp_error_q;
      resp_data_d  = resp_data_q;
      case (state_q)
         StIdle: begin
            if (i_request_valid) begin
               write_d      = i_request_write;
               write_data_d = i_request_write_data;
               if (hit) begin
                  state_d      = StAccess;
                  bf_valid_d   = hit_vector;
                  read_mask_d  = {DATA_WIDTH{~i_request_write}};
                  write_mask_d = strobe_mask & {DATA_WIDTH{i_request_write}};
                  count_d      = '0;
               end else begin
                  state_d      = StResponse;
                  resp_valid_d = 1'b1;
                  resp_error_d = ERROR_STATUS;
                  resp_data_d  = '0;
               end
            end
         end
         StAccess: begin
            if (access_done || timed_out) begin
               state_d      = StResponse;
               bf_valid_d   = '0;
               read_mask_d  = '0;
               write_mask_d = '0;
               resp_valid_d = 1'b1;
               resp_error_d = access_done ? 1'b0 : ERROR_STATUS;
               resp_data_d  = (access_done && !write_q) ? selected_data : '0;
            end else if (TIMEOUT_CYCLES != 0) begin
               count_d = count_q + CountWidth'(1);
            end
         end
         StResponse: begin
            if (i_response_ready) begin
               state_d      = StIdle;
               resp_valid_d = 1'b0;
               resp_error_d = 1'b0;
               resp_data_d  = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers; reset abandons any access in flight without a response.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= StIdle;
         write_q      <= 1'b0;
         bf_valid_q   <= '0;
         read_mask_q  <= '0;
         write_mask_q <= '0;
         write_data_q <= '0;
         count_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         bf_valid_q   <= bf_valid_d;
         read_mask_q  <= read_mask_d;
         write_mask_q <= write_mask_d;
         write_data_q <= write_data_d;
         count_q      <= count_d;
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign o_request_ready        = (state_q == StIdle);
   assign o_response_valid       = resp_valid_q;
   assign o_response_error       = resp_error_q;
   assign o_response_read_data   = resp_data_q;
   assign o_bit_field_valid      = bf_valid_q;
   assign o_bit_field_read_mask  = read_mask_q;
   assign o_bit_field_write_mask = write_mask_q;
   assign o_bit_field_write_data = write_data_q;

endmodule

// File: tb/tb_rggen_register_access_initiator.sv
// Randomized bench for the register access initiator against a transaction-level model.
module tb_rggen_register_access_initiator;

   localparam int unsigned Timeout = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_write;
   logic [7:0]   req_addr;
   logic [31:0]  req_wdata;
   logic [3:0]   req_strb;
   logic         resp_ready;
   logic [3:0]   bf_ready;
   logic [127:0] bf_rdata;

   logic         req_rdy, resp_valid, resp_err;
   logic [31:0]  resp_data, rmask, wmask, wdata_out;
   logic [3:0]   bf_valid;
   logic         req_rdy0, resp_valid0, resp_err0;
   logic [31:0]  resp_data0, rmask0, wmask0, wdata_out0;
   logic [3:0]   bf_valid0;

   int errors = 0;
   int checks = 0;
   int unsigned reg_addr[4] = '{32'h00, 32'h04, 32'h08, 32'h0C};

   always #5 clk = ~clk;

   rggen_register_access_initiator #(
      .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .REGISTERS(4),
      .REGISTER_ADDRESS({8'h0C, 8'h08, 8'h04, 8'h00}), .TIMEOUT_CYCLES(Timeout),
      .ERROR_STATUS(1'b1)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_request_valid(req_valid), .o_request_ready(req_rdy),
      .i_request_write(req_write), .i_request_address(req_addr),
      .i_request_write_data(req_wdata), .i_request_strobe(req_strb),
      .o_response_valid(resp_valid), .i_response_ready(resp_ready),
      .o_response_error(resp_err), .o_response_read_data(resp_data),
      .o_bit_field_valid(bf_valid), .o_bit_field_read_mask(rmask),
      .o_bit_field_write_mask(wmask), .o_bit_field_write_data(wdata_out),
      .i_bit_field_ready(bf_ready), .i_bit_field_read_data(bf_rdata)
   );

   rggen_register_access_initiator #(
      .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .REGISTERS(4),
      .REGISTER_ADDRESS({8'h0C, 8'h08, 8'h04, 8'h00}), .TIMEOUT_CYCLES(Timeout),
      .ERROR_STATUS(1'b0)
   ) dut0 (
      .i_clk(clk), .i_rst(rst), .i_request_valid(req_valid), .o_request_ready(req_rdy0),
      .i_request_write(req_write), .i_request_address(req_addr),
      .i_request_write_data(req_wdata), .i_request_strobe(req_strb),
      .o_response_valid(resp_valid0), .i_response_ready(resp_ready),
      .o_response_error(resp_err0), .o_response_read_data(resp_data0),
      .o_bit_field_valid(bf_valid0), .o_bit_field_read_mask(rmask0),
      .o_bit_field_write_mask(wmask0), .o_bit_field_write_data(wdata_out0),
      .i_bit_field_ready(bf_ready), .i_bit_field_read_data(bf_rdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One host transaction: d = cycles of waiting before the slot raises ready,
   // stall = response cycles before the host accepts, hold = keep a new request pending meanwhile.
   task automatic txn(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int d, input int stall, input bit hold,
                      input logic [31:0] slot_data);
      int          slot;
      bit          to;
      int          n;
      logic [31:0] exp_rd, exp_wmask, exp_rmask;
      logic [3:0]  noise;
      slot = -1;
      for (int i = 0; i < 4; i++) begin
         if (slot < 0 && (int'(addr) / 4) == (reg_addr[i] / 4)) slot = i;
      end
      to = (slot >= 0) && (d >= Timeout);
      for (int j = 0; j < 32; j++) exp_wmask[j] = wr & strb[j/8];
      exp_rmask = wr ? 32'h0 : 32'hFFFF_FFFF;

      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
      resp_ready = 1'b0; bf_ready = '0;
      @(negedge clk);
      check_eq("idle_req_ready", 32'(req_rdy), 32'd1);
      check_eq("idle_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("idle_resp_data", resp_data, 32'd0);
      tick();
      req_valid = 1'b0;

      exp_rd = 32'h0;
      if (slot >= 0) begin
         n = to ? Timeout : d + 1;
         for (int k = 1; k <= n; k++) begin
            bf_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (k == n && !to && slot_data != 32'h0) bf_rdata[slot*32+:32] = slot_data;
            noise = 4'($urandom_range(0, 15));
            noise[slot] = (!to && k == n);
            bf_ready = noise;
            if (k == n && !to && !wr) exp_rd = bf_rdata[slot*32+:32];
            @(negedge clk);
            check_eq("access_bf_valid", 32'(bf_valid), 32'(4'b0001 << slot));
            check_eq("access_read_mask", rmask, exp_rmask);
            check_eq("access_write_mask", wmask, exp_wmask);
            check_eq("access_write_data", wdata_out, wdata);
            check_eq("access_resp_valid", 32'(resp_valid), 32'd0);
            check_eq("access_req_ready", 32'(req_rdy), 32'd0);
            tick();
         end
         bf_ready = '0;
      end

      for (int s = 0; s <= stall; s++) begin
         if (hold) begin
            req_valid = 1'b1; req_write = 1'($urandom); req_addr = 8'($urandom);
            req_wdata = $urandom;
         end
         resp_ready = (s == stall);
         @(negedge clk);
         check_eq("resp_valid", 32'(resp_valid), 32'd1);
         check_eq("resp_error", 32'(resp_err), 32'((slot < 0) || to));
         check_eq("resp_data", resp_data, exp_rd);
         check_eq("resp_error_es0", 32'(resp_err0), 32'd0);
         check_eq("resp_valid_es0", 32'(resp_valid0), 32'd1);
         check_eq("resp_bf_valid", 32'(bf_valid), 32'd0);
         check_eq("resp_masks", rmask | wmask, 32'd0);
         check_eq("resp_req_ready", 32'(req_rdy), 32'd0);
         tick();
      end
      resp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      req_strb = '0; resp_ready = 1'b0; bf_ready = '0; bf_rdata = '0;
      #2;
      check_eq("reset_req_ready", 32'(req_rdy), 32'd1);
      check_eq("reset_resp_valid", 32'(resp_valid), 32'd0);
      check_eq("reset_bf_valid", 32'(bf_valid), 32'd0);
      check_eq("reset_outputs", rmask | wmask | wdata_out | resp_data | 32'(resp_err), 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Directed cases.
      txn(1'b1, 8'h08, 32'hA5A5_1234, 4'b0011, 0, 0, 1'b0, 32'h0);
      txn(1'b0, 8'h04, 32'h0, 4'b0000, 2, 0, 1'b0, 32'hDEAD_BEEF);
      txn(1'b0, 8'h10, 32'h0, 4'b1111, 0, 0, 1'b0, 32'h0);
      txn(1'b0, 8'h00, 32'h0, 4'b0000, 99, 0, 1'b0, 32'h0);
      txn(1'b0, 8'h0E, 32'h0, 4'b0000, 3, 0, 1'b0, 32'h0);
      txn(1'b0, 8'h08, 32'h0, 4'b0000, 0, 5, 1'b1, 32'h0);
      txn(1'b1, 8'h0C, 32'h1357_9BDF, 4'b1010, 1, 0, 1'b0, 32'h0);

      // Reset in the middle of an access.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h04; bf_ready = '0;
      tick();
      req_valid = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      check_eq("rst_bf_valid", 32'(bf_valid), 32'd0);
      check_eq("rst_read_mask", rmask, 32'd0);
      check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("post_rst_resp_valid", 32'(resp_valid), 32'd0);
         check_eq("post_rst_req_ready", 32'(req_rdy), 32'd1);
         tick();
      end
      txn(1'b0, 8'h04, 32'h0, 4'b0000, 0, 0, 1'b0, 32'h0BAD_CAFE);

      // Randomized traffic.
      for (int t = 0; t < 60; t++) begin
         txn(1'($urandom), 8'($urandom_range(0, 19)), $urandom, 4'($urandom),
             int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'($urandom), 32'h0);
      end
      req_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
